rggen_axi4lite_initiator: RTL and testbench
===========================================

RGGEN_AXI4LITE_INITIATOR -- requirements
Module: rggen_axi4lite_initiator

Interface
REQ-001 SHALL have parameters (name, default, meaning): ID_WIDTH, 0, AXI ID width; 0 means ID ports are 1 bit wide and tied to 0.
REQ-002 SHALL have parameter ADDRESS_WIDTH, 8, byte address width.
REQ-003 SHALL have parameter BUS_WIDTH, 32, data width; legal values are 32 and 64.
REQ-004 SHALL have parameter ID_VALUE, 0, constant driven on o_awid and o_arid.
REQ-005 SHALL have parameter PROT, 3'b000, constant driven on o_awprot and o_arprot.
REQ-006 SHALL have ports (name, direction, width, meaning): i_clk, in, 1, clock; i_rst_n, in, 1, reset, asynchronous, active-low.
REQ-007 SHALL have request ports: i_bus_valid in 1; i_bus_access in 2 (bit0=1 write, bit0=0 read); i_bus_address in ADDRESS_WIDTH; i_bus_write_data in BUS_WIDTH; i_bus_strobe in BUS_WIDTH/8.
REQ-008 SHALL have response ports: o_bus_ready out 1; o_bus_status out 2 (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR); o_bus_read_data out BUS_WIDTH.
REQ-009 SHALL have write channels: o_awvalid, i_awready, o_awid, o_awaddr, o_awprot; o_wvalid, i_wready, o_wdata, o_wstrb; i_bvalid, o_bready, i_bid, i_bresp. Widths follow AXI4-Lite, with ID width max(ID_WIDTH,1).
REQ-010 SHALL have read channels: o_arvalid, i_arready, o_arid, o_araddr, o_arprot; i_rvalid, o_rready, i_rid, i_rresp, i_rdata.

Function
REQ-011 SHALL implement an FSM with states IDLE, WRITE_REQ, WRITE_RESP, READ_REQ, READ_RESP, DONE, and SHALL allow at most one outstanding transaction.
REQ-012 In IDLE with i_bus_valid=1, SHALL register address, write data, strobe and access, then move to WRITE_REQ (bit0=1) or READ_REQ (bit0=0) on the next edge.
REQ-013 Upstream holds request signals stable while i_bus_valid=1 until o_bus_ready; the block SHALL use only the registered copies after capture.
REQ-014 On entry to WRITE_REQ, SHALL assert o_awvalid and o_wvalid together. Each SHALL stay high until its own handshake (valid&ready at the edge) and then drop independently.
REQ-015 AW and W handshakes SHALL be tracked by two done flags, completing in either order or in the same cycle. SHALL go to WRITE_RESP on the edge where both are complete.
REQ-016 In WRITE_RESP, SHALL hold o_bready=1. On i_bvalid=1, SHALL capture i_bresp into o_bus_status, set o_bus_read_data to 0, and go to DONE.
REQ-017 On entry to READ_REQ, SHALL assert o_arvalid until i_arready, then go to READ_RESP.
REQ-018 In READ_RESP, SHALL hold o_rready=1. On i_rvalid=1, SHALL capture i_rresp and i_rdata and go to DONE.
REQ-019 DONE SHALL last exactly one cycle with o_bus_ready=1, then go to IDLE. o_bus_ready SHALL be 0 in all other states.
REQ-020 A request present in IDLE the cycle after DONE SHALL be treated as a new transaction.
REQ-021 o_bus_status and o_bus_read_data SHALL be registered and SHALL hold their value until the next capture.
REQ-022 AXI valid outputs SHALL be registered (no combinational path from any AXI ready input to any valid output). Once asserted, a valid SHALL NOT drop before its handshake.
REQ-023 o_awaddr/o_araddr SHALL carry the captured address unmodified; o_wdata/o_wstrb SHALL carry the captured data and strobe.
REQ-024 i_bid and i_rid SHALL be ignored. o_awid=o_arid=ID_VALUE truncated to the ID width.
REQ-025 A bvalid or rvalid arriving in a state that does not expect it SHALL NOT be acknowledged (o_bready=o_rready=0 outside their RESP states).
REQ-026 Minimum latency with a zero-wait slave: write, capture to o_bus_ready = 4 cycles; read = 4 cycles.

Reset
REQ-027 On i_rst_n=0, SHALL asynchronously set state=IDLE and clear all valid, ready and done flags. o_bus_ready=0, o_bus_status=2'b00, o_bus_read_data=0.
REQ-028 Reset mid-transaction SHALL abandon the transaction without any response.
REQ-029 Registered address, data and strobe need no reset.

Verification
REQ-030 Write 0x10/0xDEADBEEF/strb 0xF, awready 2 cycles before wready, bresp=00: o_awvalid drops first, o_wvalid drops at wready, o_bus_ready pulses once with status 00 and read_data 0.
REQ-031 Read 0x24, arready immediate, rvalid after 3 cycles with rdata 0x12345678 and rresp=10: o_bus_read_data=0x12345678, o_bus_status=10, o_bus_ready high 1 cycle.
REQ-032 Simultaneous awready/wready in the first cycle with bvalid held high: latency 4 cycles, exactly one bvalid&bready handshake.
REQ-033 Back-to-back write then read with i_bus_valid held: second transaction starts in the IDLE cycle after DONE, and no AXI valid is asserted during DONE.
REQ-034 Reset asserted in WRITE_RESP: all outputs at reset values immediately, no o_bus_ready, next request proceeds normally.
REQ-035 Stray i_bvalid/i_rvalid in IDLE: o_bready=o_rready=0 and state stays IDLE.

Source files
------------

// File: rtl/rggen_axi4lite_initiator_if.sv
// AXI4-Lite bus bundle between the register-bus initiator and an AXI4-Lite slave.
//   master modport : initiator side (drives AW/W/AR valids, B/R readies)
//   slave modport  : target side (drives AW/W/AR readies, B/R responses)
// ID_WIDTH of 0 still yields 1-bit ID signals.
interface rggen_axi4lite_initiator_if #(
  parameter int unsigned ID_WIDTH      = 0,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned BUS_WIDTH     = 32
);
  localparam int unsigned IdW = (ID_WIDTH == 0) ? 1 : ID_WIDTH;

  logic                     awvalid;
  logic                     awready;
  logic [IdW-1:0]           awid;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH/8-1:0]   wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [IdW-1:0]           bid;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [IdW-1:0]           arid;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [IdW-1:0]           rid;
  logic [1:0]               rresp;
  logic [BUS_WIDTH-1:0]     rdata;

  modport master (
    output awvalid, awid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, arid, araddr, arprot, rready,
    input  awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rdata
  );

  modport slave (
    input  awvalid, awid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, arid, araddr, arprot, rready,
    output awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rresp, rdata
  );
endinterface

// File: rtl/rggen_axi4lite_initiator.sv
// Bridges a simple valid/ready register bus onto AXI4-Lite, one transaction at a time.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_bus_valid/access/address/write_data/strobe : request (access bit0: 1 write, 0 read)
//   o_bus_ready/status/read_data                 : response, o_bus_ready pulses for one cycle
//   axi                 : AXI4-Lite master side (rggen_axi4lite_initiator_if.master)
module rggen_axi4lite_initiator #(
  parameter int unsigned ID_WIDTH      = 0,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned ID_VALUE      = 0,
  parameter logic [2:0]  PROT          = 3'b000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_bus_valid,
  input  logic [1:0]               i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
  input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_bus_strobe,
  output logic                     o_bus_ready,
  output logic [1:0]               o_bus_status,
  output logic [BUS_WIDTH-1:0]     o_bus_read_data,
  rggen_axi4lite_initiator_if.master axi
);
  localparam int unsigned IdW = (ID_WIDTH == 0) ? 1 : ID_WIDTH;
  localparam logic [IdW-1:0] IdValue = IdW'(ID_VALUE);

  typedef enum logic [2:0] {
    StIdle, StWriteReq, StWriteResp, StReadReq, StReadResp, StDone
  } state_e;

  state_e state_q, state_d;
  logic   awvalid_q, awvalid_d;
  logic   wvalid_q, wvalid_d;
  logic   arvalid_q, arvalid_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   capture;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0]     wdata_q;
  logic [BUS_WIDTH/8-1:0]   strb_q;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = awvalid_q & axi.awready;
  assign w_hs  = wvalid_q & axi.wready;
  assign ar_hs = arvalid_q & axi.arready;

  // IDs returned by the slave carry no information here.
  logic unused_inputs;
  assign unused_inputs = ^{axi.bid, axi.rid, i_bus_access[1]};

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_bus_valid) begin
          capture   = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (i_bus_access[0]) begin
            state_d   = StWriteReq;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StReadReq;
            arvalid_d = 1'b1;
          end
        end
      end
      StWriteReq: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Both channels may finish in the same cycle or in either order.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d = StWriteResp;
        end
      end
      StWriteResp: if (axi.bvalid) state_d = StDone;
      StReadReq: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = StReadResp;
        end
      end
      StReadResp: if (axi.rvalid) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (capture) begin
      addr_q  <= i_bus_address;
      wdata_q <= i_bus_write_data;
      strb_q  <= i_bus_strobe;
    end
  end

  // Response registers hold until the next completed transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bus_status    <= 2'b00;
      o_bus_read_data <= '0;
    end else if ((state_q == StWriteResp) && axi.bvalid) begin
      o_bus_status    <= axi.bresp;
      o_bus_read_data <= '0;
    end else if ((state_q == StReadResp) && axi.rvalid) begin
      o_bus_status    <= axi.rresp;
      o_bus_read_data <= axi.rdata;
    end
  end

  assign o_bus_ready = (state_q == StDone);

  assign axi.awvalid = awvalid_q;
  assign axi.awid    = IdValue;
  assign axi.awaddr  = addr_q;
  assign axi.awprot  = PROT;
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = strb_q;
  assign axi.bready  = (state_q == StWriteResp);
  assign axi.arvalid = arvalid_q;
  assign axi.arid    = IdValue;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = PROT;
  assign axi.rready  = (state_q == StReadResp);
endmodule

// File: tb/tb_rggen_axi4lite_initiator.sv
// Directed bench for rggen_axi4lite_initiator: vector table of transactions with per-channel
// slave delays and hand-computed latency/response, plus stray-response and mid-reset sequences.
module tb_rggen_axi4lite_initiator;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_bus_valid;
  logic [1:0]  i_bus_access;
  logic [7:0]  i_bus_address;
  logic [31:0] i_bus_write_data;
  logic [3:0]  i_bus_strobe;
  logic        o_bus_ready;
  logic [1:0]  o_bus_status;
  logic [31:0] o_bus_read_data;

  int checks = 0;
  int errors = 0;

  rggen_axi4lite_initiator_if #(
    .ID_WIDTH      (4),
    .ADDRESS_WIDTH (8),
    .BUS_WIDTH     (32)
  ) axi_if ();

  rggen_axi4lite_initiator #(
    .ID_WIDTH      (4),
    .ADDRESS_WIDTH (8),
    .BUS_WIDTH     (32),
    .ID_VALUE      (21),
    .PROT          (3'b010)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_bus_valid      (i_bus_valid),
    .i_bus_access     (i_bus_access),
    .i_bus_address    (i_bus_address),
    .i_bus_write_data (i_bus_write_data),
    .i_bus_strobe     (i_bus_strobe),
    .o_bus_ready      (o_bus_ready),
    .o_bus_status     (o_bus_status),
    .o_bus_read_data  (o_bus_read_data),
    .axi              (axi_if)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_d;
    int          w_d;
    int          ar_d;
    int          b_d;
    int          r_d;
    bit          bhold;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          chain;
    int          exp_lat;
    logic [1:0]  exp_status;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_slave();
    axi_if.awready = 1'b0;
    axi_if.wready  = 1'b0;
    axi_if.arready = 1'b0;
    axi_if.bvalid  = 1'b0;
    axi_if.rvalid  = 1'b0;
  endtask

  // Starts #1 after a clock edge with the DUT in IDLE (or in DONE when from_done is set).
  task automatic run_txn(input vec_t v, input bit from_done);
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int aw_n = 0, w_n = 0, ar_n = 0, b_n = 0, r_n = 0;
    int aw_c = -1, w_c = -1, ar_c = -1, lat = -1;
    bit pa, pw, par, pb, pr;
    logic [7:0]  s_awaddr = '0, s_araddr = '0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    i_bus_valid      = 1'b1;
    i_bus_access     = {1'b0, v.write};
    i_bus_address    = v.addr;
    i_bus_write_data = v.wdata;
    i_bus_strobe     = v.strb;
    if (from_done) begin
      chk("done_no_valid", {axi_if.awvalid, axi_if.wvalid, axi_if.arvalid}, 0);
      @(posedge i_clk); #1;
    end
    for (int c = 1; c <= 40; c++) begin
      axi_if.awready = axi_if.awvalid && (aw_cnt >= v.aw_d);
      axi_if.wready  = axi_if.wvalid && (w_cnt >= v.w_d);
      axi_if.arready = axi_if.arvalid && (ar_cnt >= v.ar_d);
      axi_if.bvalid  = v.bhold ? 1'b1 : (axi_if.bready && (b_cnt >= v.b_d));
      axi_if.bresp   = v.resp;
      axi_if.rvalid  = axi_if.rready && (r_cnt >= v.r_d);
      axi_if.rresp   = v.resp;
      axi_if.rdata   = v.rdata;
      if (axi_if.awvalid && axi_if.awready) begin
        aw_n++; aw_c = c; s_awaddr = axi_if.awaddr;
      end
      if (axi_if.wvalid && axi_if.wready) begin
        w_n++; w_c = c; s_wdata = axi_if.wdata; s_wstrb = axi_if.wstrb;
      end
      if (axi_if.arvalid && axi_if.arready) begin
        ar_n++; ar_c = c; s_araddr = axi_if.araddr;
      end
      if (axi_if.bvalid && axi_if.bready) b_n++;
      if (axi_if.rvalid && axi_if.rready) r_n++;
      if (o_bus_ready) begin
        lat = c;
        chk("valids_in_done", {axi_if.awvalid, axi_if.wvalid, axi_if.arvalid}, 0);
        break;
      end
      pa  = axi_if.awvalid && !axi_if.awready;
      pw  = axi_if.wvalid && !axi_if.wready;
      par = axi_if.arvalid && !axi_if.arready;
      pb  = axi_if.bready && !axi_if.bvalid;
      pr  = axi_if.rready && !axi_if.rvalid;
      @(posedge i_clk); #1;
      if (pa)  aw_cnt++;
      if (pw)  w_cnt++;
      if (par) ar_cnt++;
      if (pb)  b_cnt++;
      if (pr)  r_cnt++;
    end
    chk("latency", lat, v.exp_lat);
    chk("status", o_bus_status, v.exp_status);
    chk("read_data", o_bus_read_data, v.exp_rdata);
    if (v.write) begin
      chk("aw_hs_cycle", aw_c, 2 + v.aw_d);
      chk("w_hs_cycle", w_c, 2 + v.w_d);
      chk("aw_hs_count", aw_n, 1);
      chk("w_hs_count", w_n, 1);
      chk("b_hs_count", b_n, 1);
      chk("ar_hs_count", ar_n, 0);
      chk("awaddr", s_awaddr, v.addr);
      chk("wdata", s_wdata, v.wdata);
      chk("wstrb", s_wstrb, v.strb);
    end else begin
      chk("ar_hs_cycle", ar_c, 2 + v.ar_d);
      chk("ar_hs_count", ar_n, 1);
      chk("r_hs_count", r_n, 1);
      chk("aw_hs_count", aw_n + w_n, 0);
      chk("araddr", s_araddr, v.addr);
    end
    idle_slave();
    if (!v.chain) begin
      i_bus_valid = 1'b0;
      @(posedge i_clk); #1;
      chk("ready_one_cycle", o_bus_ready, 0);
      chk("status_held", o_bus_status, v.exp_status);
      chk("read_data_held", o_bus_read_data, v.exp_rdata);
    end
  endtask

  initial begin
    // write, addr, wdata, strb, aw_d, w_d, ar_d, b_d, r_d, bhold, resp, rdata, chain,
    // exp_lat, exp_status, exp_rdata   (latency = 4 + max(aw_d,w_d) + b_d, or 4 + ar_d + r_d)
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 2, 0, 0, 0, 1'b0, 2'b00, 32'h0,
                1'b0, 6, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 8'h24, 32'h0, 4'h0, 0, 0, 0, 0, 3, 1'b0, 2'b10, 32'h12345678,
                1'b0, 7, 2'b10, 32'h12345678};
    vecs[2] = '{1'b1, 8'h30, 32'hA5A5A5A5, 4'h3, 0, 0, 0, 0, 0, 1'b1, 2'b01, 32'h0,
                1'b0, 4, 2'b01, 32'h0};
    vecs[3] = '{1'b1, 8'h44, 32'h11223344, 4'hC, 3, 1, 0, 2, 0, 1'b0, 2'b11, 32'h0,
                1'b0, 9, 2'b11, 32'h0};
    vecs[4] = '{1'b1, 8'h08, 32'hCAFEF00D, 4'hF, 1, 1, 0, 0, 0, 1'b0, 2'b00, 32'h0,
                1'b1, 5, 2'b00, 32'h0};
    vecs[5] = '{1'b0, 8'hFC, 32'h0, 4'h0, 0, 0, 2, 0, 0, 1'b0, 2'b01, 32'h0BADF00D,
                1'b0, 6, 2'b01, 32'h0BADF00D};
    vecs[6] = '{1'b0, 8'h00, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1'b0, 2'b00, 32'hFFFFFFFF,
                1'b0, 4, 2'b00, 32'hFFFFFFFF};
    vecs[7] = '{1'b0, 8'h80, 32'h0, 4'h0, 0, 0, 0, 0, 1, 1'b0, 2'b10, 32'h87654321,
                1'b0, 5, 2'b10, 32'h87654321};

    i_rst_n          = 1'b0;
    i_bus_valid      = 1'b0;
    i_bus_access     = 2'b00;
    i_bus_address    = '0;
    i_bus_write_data = '0;
    i_bus_strobe     = '0;
    axi_if.bid       = 4'hA;
    axi_if.rid       = 4'h3;
    axi_if.bresp     = 2'b00;
    axi_if.rresp     = 2'b00;
    axi_if.rdata     = '0;
    idle_slave();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_bus_ready", o_bus_ready, 0);
    chk("rst_status", o_bus_status, 0);
    chk("rst_read_data", o_bus_read_data, 0);
    chk("rst_valids", {axi_if.awvalid, axi_if.wvalid, axi_if.arvalid}, 0);
    chk("rst_readies", {axi_if.bready, axi_if.rready}, 0);
    chk("awid_trunc", axi_if.awid, 4'h5);
    chk("arid_trunc", axi_if.arid, 4'h5);
    chk("prot", {axi_if.awprot, axi_if.arprot}, 6'b010010);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], (i > 0) && vecs[i-1].chain);
    end

    // Stray responses while idle must be ignored.
    axi_if.bvalid = 1'b1;
    axi_if.rvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk); #1;
      chk("stray_readies", {axi_if.bready, axi_if.rready}, 0);
      chk("stray_idle", {o_bus_ready, axi_if.awvalid, axi_if.wvalid, axi_if.arvalid}, 0);
    end
    idle_slave();

    // Reset while waiting for the write response.
    i_bus_valid      = 1'b1;
    i_bus_access     = 2'b01;
    i_bus_address    = 8'h50;
    i_bus_write_data = 32'h00000055;
    i_bus_strobe     = 4'hF;
    axi_if.awready   = 1'b1;
    axi_if.wready    = 1'b1;
    for (int k = 0; k < 10 && !axi_if.bready; k++) begin
      @(posedge i_clk); #1;
    end
    chk("reach_write_resp", axi_if.bready, 1);
    #2;
    i_rst_n     = 1'b0;
    i_bus_valid = 1'b0;
    #1;
    chk("midrst_bus_ready", o_bus_ready, 0);
    chk("midrst_status", o_bus_status, 0);
    chk("midrst_read_data", o_bus_read_data, 0);
    chk("midrst_valids", {axi_if.awvalid, axi_if.wvalid, axi_if.arvalid}, 0);
    chk("midrst_readies", {axi_if.bready, axi_if.rready}, 0);
    idle_slave();
    @(posedge i_clk); #1;
    chk("midrst_no_ready", o_bus_ready, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("post_rst_idle", {o_bus_ready, axi_if.awvalid, axi_if.arvalid, axi_if.bready}, 0);
    run_txn(vecs[0], 1'b0);
    run_txn(vecs[1], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
